// File: rtl/wam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wam_pkg
// Description : Shared whack-a-mole constants and the spawner state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wam_pkg;

    localparam int          c_NUM_HOLES = 5;
    // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        SHOW = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } spawn_state_t;

endpackage
`default_nettype wire

// File: rtl/mole_spawner_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : 16-bit Fibonacci LFSR, free-running every cycle outside reset.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import wam_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = ^(r_state & c_LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= {w_fb, r_state[15:1]};
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/mole_spawner.sv
`default_nettype none
// ============================================================================
// Module      : mole_spawner
// Description : Runs a game of timed rounds, emitting a random mole pattern
//               per round. Define DIFFICULTY_RAMP_EN to shorten rounds.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_spawner
    import wam_pkg::*;
#(
    parameter int          ROUND_CYCLES     = 100_000_000,
    parameter int          MIN_ROUND_CYCLES = 25_000_000,
    parameter int          RAMP_STEP        = 5_000_000,
    parameter int          NUM_ROUNDS       = 30,
    parameter int          MAX_MOLES        = 2,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] board_state,
    output logic       load,
    output logic [4:0] loadval,
    output logic [7:0] round_cnt,
    output logic       game_active,
    output logic       game_over
);

    localparam logic [31:0] c_ROUND = 32'(ROUND_CYCLES);

    if (ROUND_CYCLES < 4 || MIN_ROUND_CYCLES < 4 || MIN_ROUND_CYCLES > ROUND_CYCLES ||
        RAMP_STEP < 0 || NUM_ROUNDS < 1 || NUM_ROUNDS > 255 ||
        MAX_MOLES < 1 || MAX_MOLES > 5 || LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("mole_spawner: illegal parameter combination");
    end

    spawn_state_t r_state, w_next;
    logic [15:0]  w_lfsr;
    logic         w_lfsr_unused;
    logic [4:0]   w_raw, w_pattern;
    logic [2:0]   w_kept;
    logic [31:0]  r_timer, r_interval, w_ramped;
    logic         r_first, w_round_end;
    logic         r_load, r_active, r_over;
    logic [4:0]   r_loadval;
    logic [7:0]   r_round_cnt;
    logic         w_load_d, w_active_d, w_over_d;
    logic [4:0]   w_loadval_d;
    logic [7:0]   w_round_cnt_d;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (w_lfsr)
    );

    // Only the low byte feeds the pattern
    assign w_lfsr_unused = ^w_lfsr[15:8];

    always_comb begin
        w_raw = w_lfsr[4:0];
        if (w_raw == 5'd0) begin
            w_raw = 5'd1 << (w_lfsr[7:5] % 3'd5);
        end
        w_pattern = '0;
        w_kept    = '0;
        for (int i = 0; i < c_NUM_HOLES; i++) begin
            if (w_raw[i] && (w_kept < 3'(MAX_MOLES))) begin
                w_pattern[i] = 1'b1;
                w_kept       = w_kept + 3'd1;
            end
        end
    end

`ifdef DIFFICULTY_RAMP_EN
    localparam logic [31:0] c_MIN  = 32'(MIN_ROUND_CYCLES);
    localparam logic [31:0] c_STEP = 32'(RAMP_STEP);
    assign w_ramped = (r_interval >= c_MIN + c_STEP) ? (r_interval - c_STEP) : c_MIN;
`else
    assign w_ramped = c_ROUND;
`endif

    // Board-clear is only trusted once the board has had two cycles to latch the load
    assign w_round_end = (r_timer == r_interval - 32'd1) ||
                         ((r_timer >= 32'd2) && (board_state == 5'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ARM;
            ARM:     w_next = SHOW;
            SHOW:    if (w_round_end) w_next = (r_round_cnt == 8'(NUM_ROUNDS)) ? DONE : NEXT;
            NEXT:    w_next = ARM;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load_d      = 1'b0;
        w_over_d      = 1'b0;
        w_loadval_d   = r_loadval;
        w_round_cnt_d = r_round_cnt;
        w_active_d    = r_active;
        case (r_state)
            ARM: begin
                w_load_d      = 1'b1;
                w_loadval_d   = w_pattern;
                w_round_cnt_d = r_first ? 8'd1 : (r_round_cnt + 8'd1);
                w_active_d    = 1'b1;
            end
            DONE: begin
                w_load_d    = 1'b1;
                w_loadval_d = '0;
                w_over_d    = 1'b1;
                w_active_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer    <= '0;
            r_interval <= c_ROUND;
            r_first    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) r_first <= 1'b1;
                ARM: begin
                    r_timer <= '0;
                    r_first <= 1'b0;
                    if (r_first) r_interval <= c_ROUND;
                end
                SHOW:    r_timer <= r_timer + 32'd1;
                NEXT:    r_interval <= w_ramped;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load      <= 1'b0;
            r_loadval   <= '0;
            r_round_cnt <= '0;
            r_active    <= 1'b0;
            r_over      <= 1'b0;
        end else begin
            r_load      <= w_load_d;
            r_loadval   <= w_loadval_d;
            r_round_cnt <= w_round_cnt_d;
            r_active    <= w_active_d;
            r_over      <= w_over_d;
        end
    end

    assign load        = r_load;
    assign loadval     = r_loadval;
    assign round_cnt   = r_round_cnt;
    assign game_active = r_active;
    assign game_over   = r_over;

endmodule
`default_nettype wire
